// File: rtl/ham_tx_ctrl.sv
// ham_tx_ctrl: byte-level transmit controller for the Hamming link.
// Accepts one byte per valid/ready handshake, encodes the low then the high
// nibble as (7,4) Hamming codewords and sends each as a framed serial word:
// start(0), 7 codeword bits MSB first, [even parity], stop(1).
//
// Optional feature macro: HAM_TX_PARITY_EN (adds the parity bit per frame).
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream byte valid
//   in_data    upstream byte, [3:0] sent first, [7:4] second
//   in_ready   controller is idle and can accept a byte
//   tx_out     serial line, idles high
//   busy       a byte is being transmitted
//   byte_done  one-cycle pulse after the high frame's stop bit
module ham_tx_ctrl #(
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       tx_out,
    output logic       busy,
    output logic       byte_done
);

    localparam int unsigned BAUD_W = 8;
    localparam int unsigned CODE_W = 7;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYCLES - 1);

`ifdef HAM_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t              r_state;
    logic [BAUD_W-1:0]   r_baud;
    logic [2:0]          r_bit_idx;
    logic                r_half;
    logic [7:0]          r_byte;
    logic [CODE_W-1:0]   r_shift;
    logic                r_in_ready;
    logic                r_busy;
    logic                r_tx;
    logic                r_done;
`ifdef HAM_TX_PARITY_EN
    logic                r_par;
`endif

    logic [CODE_W-1:0]   w_code_lo;
    logic [CODE_W-1:0]   w_code_hi;
    logic [CODE_W-1:0]   w_code;
    logic                w_bit_end;

    // One encoder per nibble; half selects which codeword is loaded.
    Hamming_encoder u_enc_lo (
        .i_nibble (r_byte[3:0]),
        .o_code   (w_code_lo)
    );

    Hamming_encoder u_enc_hi (
        .i_nibble (r_byte[7:4]),
        .o_code   (w_code_hi)
    );

    assign w_code    = r_half ? w_code_hi : w_code_lo;
    assign w_bit_end = (r_baud == BAUD_LAST);

    // Sequencer. Outputs are registered alongside the state they belong to,
    // so they change on the same edge the state does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_half     <= 1'b0;
            r_byte     <= '0;
            r_shift    <= '0;
`ifdef HAM_TX_PARITY_EN
            r_par      <= 1'b0;
`endif
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_byte     <= in_data;
                        r_half     <= 1'b0;
                        r_baud     <= '0;
                        r_state    <= S_START;
                        r_tx       <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        // Codeword MSB goes straight to the line; the rest waits in the shifter.
                        r_state   <= S_DATA;
                        r_baud    <= '0;
                        r_bit_idx <= 3'd6;
                        r_tx      <= w_code[6];
                        r_shift   <= {w_code[5:0], 1'b0};
`ifdef HAM_TX_PARITY_EN
                        r_par     <= ^w_code;
`endif
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd0) begin
`ifdef HAM_TX_PARITY_EN
                            r_state <= S_PAR;
                            r_tx    <= r_par;
`else
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx - 3'd1;
                            r_tx      <= r_shift[6];
                            r_shift   <= {r_shift[5:0], 1'b0};
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
`ifdef HAM_TX_PARITY_EN
                S_PAR: begin
                    if (w_bit_end) begin
                        r_state <= S_STOP;
                        r_baud  <= '0;
                        r_tx    <= 1'b1;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (!r_half) begin
                            // High frame follows with no idle gap.
                            r_half  <= 1'b1;
                            r_state <= S_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state    <= S_IDLE;
                            r_tx       <= 1'b1;
                            r_done     <= 1'b1;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b0;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_baud     <= '0;
                    r_bit_idx  <= '0;
                    r_tx       <= 1'b1;
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign tx_out    = r_tx;
    assign byte_done = r_done;

endmodule

// Hamming_encoder: (7,4) encoder. Codeword positions 1..7 map to
// o_code[6..0]; parity at positions 1,2,4, data d3,d2,d1,d0 at 3,5,6,7.
//   i_nibble  4-bit data
//   o_code    7-bit codeword, o_code[6] is position 1
module Hamming_encoder (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_code
);

    logic w_p1;
    logic w_p2;
    logic w_p4;

    assign w_p1   = i_nibble[3] ^ i_nibble[2] ^ i_nibble[0];
    assign w_p2   = i_nibble[3] ^ i_nibble[1] ^ i_nibble[0];
    assign w_p4   = i_nibble[2] ^ i_nibble[1] ^ i_nibble[0];
    assign o_code = {w_p1, w_p2, i_nibble[3], w_p4, i_nibble[2], i_nibble[1], i_nibble[0]};

endmodule

// File: tb/tb_ham_tx_ctrl.sv
// tb_ham_tx_ctrl: scoreboard bench for ham_tx_ctrl at BIT_CYCLES 1 and 4.
// Stimulus pushes the expected serial line image of each byte; a monitor
// per instance detects the handshake, samples the line and compares.
module tb_ham_tx_ctrl;

`ifdef HAM_TX_PARITY_EN
    localparam int unsigned FB = 10;
`else
    localparam int unsigned FB = 9;
`endif
    localparam int unsigned TOT = 2 * FB;

    typedef logic [TOT-1:0] line_t;   // MSB is the first bit on the line

`ifdef HAM_TX_PARITY_EN
    localparam line_t LIT42 = 20'b0010101011_0100110011;
`else
    localparam line_t LIT42 = 18'b001010101_010011001;
`endif

    logic        clk;
    int unsigned n_cmp;
    int unsigned n_bad;
    int unsigned fin_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line image of a byte built from the positional Hamming definition:
    // data in non-power-of-two positions, each parity position p covers
    // every other position whose index has bit p set.
    function automatic line_t model(input logic [7:0] d);
        line_t      v;
        logic [3:0] nib;
        logic [7:1] pos;
        v = '0;
        for (int h = 0; h < 2; h++) begin
            nib = (h == 0) ? d[3:0] : d[7:4];
            pos = '0;
            pos[3] = nib[3];
            pos[5] = nib[2];
            pos[6] = nib[1];
            pos[7] = nib[0];
            for (int p = 1; p <= 4; p = p * 2)
                for (int k = 1; k <= 7; k++)
                    if (k != p && (k & p) != 0) pos[p] = pos[p] ^ pos[k];
            v = {v[TOT-2:0], 1'b0};
            for (int k = 1; k <= 7; k++) v = {v[TOT-2:0], pos[k]};
`ifdef HAM_TX_PARITY_EN
            v = {v[TOT-2:0], ^pos};
`endif
            v = {v[TOT-2:0], 1'b1};
        end
        return v;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned B = (g == 0) ? 1 : 4;

        logic       rst_n;
        logic       in_valid;
        logic [7:0] in_data;
        logic       in_ready;
        logic       tx_out;
        logic       busy;
        logic       byte_done;
        line_t      q[$];

        ham_tx_ctrl #(.BIT_CYCLES(B)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_data   (in_data),
            .in_ready  (in_ready),
            .tx_out    (tx_out),
            .busy      (busy),
            .byte_done (byte_done)
        );

        task automatic wait_ready();
            int unsigned n = 0;
            @(negedge clk);
            while (in_ready !== 1'b1 && n < 30 * B + 10) begin
                @(negedge clk);
                n++;
            end
            if (in_ready !== 1'b1) begin
                n_cmp++;
                n_bad++;
                $display("FAIL [B=%0d] accept_timeout: in_ready=%b, required 1", B, in_ready);
            end
        endtask

        // Offer a byte and return just after the accepting edge.
        task automatic send(input logic [7:0] d, input line_t e);
            in_data  = d;
            in_valid = 1'b1;
            q.push_back(e);
            wait_ready();
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        endtask

        task automatic idle(input int unsigned n);
            repeat (n) begin
                @(posedge clk);
                #1;
                in_data = 8'($urandom);
            end
        endtask

        initial begin : stim
            logic [7:0] d;
            rst_n    = 1'b1;
            in_valid = 1'b0;
            in_data  = '0;
            #1 rst_n = 1'b0;
            #2;
            n_cmp++;
            if (tx_out !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || byte_done !== 1'b0) begin
                n_bad++;
                $display("FAIL [B=%0d] reset_state: tx=%b busy=%b rdy=%b done=%b, required 1 0 1 0",
                         B, tx_out, busy, in_ready, byte_done);
            end
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            idle(2);

            send(8'h42, LIT42);
            idle(2);
            send(8'h00, model(8'h00));
            idle(1);
            // Back-to-back: second byte waits with valid held high.
            send(8'h42, LIT42);
            send(8'h00, model(8'h00));

            // Reset in the middle of the high frame's data bits.
            d = 8'($urandom);
            send(d, model(d));
            repeat (FB * B + 4 * B) @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            n_cmp++;
            if (tx_out !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || byte_done !== 1'b0) begin
                n_bad++;
                $display("FAIL [B=%0d] async_reset: tx=%b busy=%b rdy=%b done=%b, required 1 0 1 0",
                         B, tx_out, busy, in_ready, byte_done);
            end
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            idle(2);
            d = 8'($urandom);
            send(d, model(d));

            for (int i = 0; i < 25; i++) begin
                idle($urandom_range(2, 0));
                d = 8'($urandom);
                send(d, model(d));
            end

            idle(TOT * B + 4);
            n_cmp++;
            if (q.size() != 0) begin
                n_bad++;
                $display("FAIL [B=%0d] drain: %0d bytes never sent, required 0", B, q.size());
            end
            fin_cnt++;
        end

        initial begin : mon
            line_t       exp_v;
            line_t       act_v;
            line_t       pref;
            int unsigned nb;
            int unsigned bad_cyc;
            logic        aborted;
            @(negedge clk);
            forever begin
                if (rst_n === 1'b1 && in_valid === 1'b1 && in_ready === 1'b1) begin
                    act_v   = '0;
                    nb      = 0;
                    bad_cyc = 0;
                    aborted = 1'b0;
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL [B=%0d] accept: byte 0x%02h taken with nothing offered", B, in_data);
                        exp_v = '0;
                    end else begin
                        exp_v = q.pop_front();
                    end
                    for (int i = 0; i < int'(TOT) && !aborted; i++) begin
                        for (int c = 0; c < int'(B) && !aborted; c++) begin
                            @(negedge clk);
                            if (rst_n !== 1'b1) begin
                                aborted = 1'b1;
                            end else begin
                                if (c == 0) begin
                                    act_v = {act_v[TOT-2:0], tx_out};
                                    nb++;
                                end
                                if (tx_out !== exp_v[TOT-1-i] || busy !== 1'b1 || in_ready !== 1'b0)
                                    bad_cyc++;
                            end
                        end
                    end
                    pref = exp_v >> (TOT - nb);
                    n_cmp++;
                    if (act_v !== pref || bad_cyc != 0) begin
                        n_bad++;
                        $display("FAIL [B=%0d] line: got %b with %0d bad cycles, required %b (%0d bits)",
                                 B, act_v, bad_cyc, pref, nb);
                    end
                    if (aborted) begin
                        n_cmp++;
                        if (tx_out !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || byte_done !== 1'b0) begin
                            n_bad++;
                            $display("FAIL [B=%0d] abort: tx=%b busy=%b rdy=%b done=%b, required 1 0 1 0",
                                     B, tx_out, busy, in_ready, byte_done);
                        end
                    end else begin
                        @(negedge clk);
                        n_cmp++;
                        if (byte_done !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || tx_out !== 1'b1) begin
                            n_bad++;
                            $display("FAIL [B=%0d] done: done=%b rdy=%b busy=%b tx=%b, required 1 1 0 1",
                                     B, byte_done, in_ready, busy, tx_out);
                        end
                    end
                end else begin
                    @(negedge clk);
                    n_cmp++;
                    if (byte_done !== 1'b0 || tx_out !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
                        n_bad++;
                        $display("FAIL [B=%0d] idle: done=%b tx=%b busy=%b rdy=%b, required 0 1 0 1",
                                 B, byte_done, tx_out, busy, in_ready);
                    end
                end
            end
        end
    end

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        fin_cnt = 0;
        fork
            wait (fin_cnt == 2);
            begin
                #200000;
                n_cmp++;
                n_bad++;
                $display("FAIL global_timeout: finished=%0d, required 2", fin_cnt);
            end
        join_any
        disable fork;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
